// File: rtl/sdmac_reg_initiator_if.sv
// sdmac_reg_initiator_if
// Purpose : bundles the command channel, response channel and SDMAC register
//           bus of the register-cycle initiator.
// Signals : cmd_*     command request (valid/ready), byte address, rw, wdata
//           rsp_*     response (valid/ready), read data, timeout error
//           addr, dmac_n, as_n, rw, mid   bus cycle driven to the register file
//           reg_od, reg_dsk_n             read data / termination from it
//           busy      initiator not idle
// Modports: master = initiator side, slave = requester + register file side.
interface sdmac_reg_initiator_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rw;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] addr;
  logic              dmac_n;
  logic              as_n;
  logic              rw;
  logic [DATA_W-1:0] mid;
  logic [DATA_W-1:0] reg_od;
  logic              reg_dsk_n;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, rsp_ready, reg_od, reg_dsk_n,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           addr, dmac_n, as_n, rw, mid, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, rsp_ready, reg_od, reg_dsk_n,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           addr, dmac_n, as_n, rw, mid, busy
  );
endinterface

// File: rtl/sdmac_reg_initiator.sv
// sdmac_reg_initiator
// Purpose : runs one CPU-style register cycle (DMAC_, AS_, RW, ADDR, MID) per
//           accepted command against the SDMAC register file, waits for the
//           REG_DSK_ termination and returns read data / status.
// Ports   : i_clk   system clock, rising edge
//           i_rst   asynchronous active-high reset
//           if_bus  sdmac_reg_initiator_if.master (command, response, bus)
// Params  : TIMEOUT_CYCLES  WAIT cycles without termination before abort (2..255)
// Macro   : REGINIT_TIMEOUT_EN  enables the WAIT-state timeout counter and
//           RSP_ERR; when undefined WAIT waits forever and RSP_ERR is 0.
// All outputs are registered; each output register is loaded from the value
// the output must have in the state being entered.
module sdmac_reg_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sdmac_reg_initiator_if.master if_bus
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic              r_dmac_n,    w_dmac_n_nxt;
  logic              r_as_n,      w_as_n_nxt;
  logic              r_rw,        w_rw_nxt;
  logic [DATA_W-1:0] r_mid,       w_mid_nxt;
  logic              r_busy,      w_busy_nxt;
`ifdef REGINIT_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic              r_rsp_err,   w_rsp_err_nxt;
  logic [7:0]        r_tmo_cnt,   w_tmo_cnt_nxt;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_addr_nxt      = r_addr;
    w_rw_nxt        = r_rw;
    w_mid_nxt       = r_mid;
`ifdef REGINIT_TIMEOUT_EN
    w_rsp_err_nxt   = r_rsp_err;
    w_tmo_cnt_nxt   = r_tmo_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (if_bus.cmd_valid) begin
          w_state_nxt = S_SETUP;
          w_addr_nxt  = if_bus.cmd_addr;
          w_rw_nxt    = if_bus.cmd_rw;
          w_mid_nxt   = if_bus.cmd_rw ? '0 : if_bus.cmd_wdata;
        end
      end
      S_SETUP: w_state_nxt = S_STROBE;
      S_STROBE: begin
        w_state_nxt = S_WAIT;
`ifdef REGINIT_TIMEOUT_EN
        w_tmo_cnt_nxt = '0;
`endif
      end
      S_WAIT: begin
        // Termination is checked first so it wins over a same-edge timeout.
        if (!if_bus.reg_dsk_n) begin
          w_state_nxt     = S_RECOVER;
          w_rsp_rdata_nxt = r_rw ? if_bus.reg_od : '0;
`ifdef REGINIT_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
`endif
        end
`ifdef REGINIT_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt     = S_RECOVER;
          w_rsp_rdata_nxt = '1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_tmo_cnt_nxt   = r_tmo_cnt + 8'd1;
        end
`endif
      end
      S_RECOVER: begin
        // Bus lines were held through RECOVER; park them as RESP is entered.
        w_state_nxt = S_RESP;
        w_addr_nxt  = '0;
        w_rw_nxt    = 1'b1;
        w_mid_nxt   = '0;
      end
      S_RESP: begin
        if (if_bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Strobes and flags follow the state being entered.
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_dmac_n_nxt    = !(w_state_nxt inside {S_SETUP, S_STROBE, S_WAIT});
    w_as_n_nxt      = !(w_state_nxt inside {S_STROBE, S_WAIT});
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_dmac_n    <= 1'b1;
      r_as_n      <= 1'b1;
      r_rw        <= 1'b1;
      r_mid       <= '0;
      r_busy      <= 1'b0;
`ifdef REGINIT_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
      r_tmo_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_addr      <= w_addr_nxt;
      r_dmac_n    <= w_dmac_n_nxt;
      r_as_n      <= w_as_n_nxt;
      r_rw        <= w_rw_nxt;
      r_mid       <= w_mid_nxt;
      r_busy      <= w_busy_nxt;
`ifdef REGINIT_TIMEOUT_EN
      r_rsp_err   <= w_rsp_err_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign if_bus.cmd_ready = r_cmd_ready;
  assign if_bus.rsp_valid = r_rsp_valid;
  assign if_bus.rsp_rdata = r_rsp_rdata;
  assign if_bus.addr      = r_addr;
  assign if_bus.dmac_n    = r_dmac_n;
  assign if_bus.as_n      = r_as_n;
  assign if_bus.rw        = r_rw;
  assign if_bus.mid       = r_mid;
  assign if_bus.busy      = r_busy;
`ifdef REGINIT_TIMEOUT_EN
  assign if_bus.rsp_err   = r_rsp_err;
`else
  assign if_bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sdmac_reg_initiator.sv
// tb_sdmac_reg_initiator
// Purpose : scoreboard bench for sdmac_reg_initiator with a simple register
//           file target that terminates a programmable number of cycles
//           after AS_ falls. Inputs change 2 time units after the rising
//           edge; outputs are sampled on the falling edge.
module tb_sdmac_reg_initiator;

`ifdef REGINIT_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 64;
`endif
  localparam int NEVER = 100000;

  typedef struct {
    logic [7:0]  addr;
    logic        rw;
    logic [31:0] mid;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } sb_t;

  logic clk;
  logic rst;
  sdmac_reg_initiator_if u_if ();

  sdmac_reg_initiator #(.TIMEOUT_CYCLES(TB_TMO)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .if_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expectation for the next command, set by the stimulus before it is driven
  logic [31:0] exp_rd;
  logic        exp_err;
  int          exp_lat;
  int          tgt_extra = 0;
  logic [31:0] tgt_od    = '0;

  // Scoreboard/target state, owned by the monitor
  sb_t         sb_q[$];
  int          last_accept = 0;
  int          hs_edge     = 0;
  int          as_low_cnt  = 0;
  int          as_high_cnt = 0;
  int          last_gap    = 0;
  logic        rsp_seen    = 1'b0;
  logic [7:0]  snap_addr;
  logic [31:0] snap_mid;

  // Monitor, scoreboard and register-file target
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sb_q.delete();
      rsp_seen   = 1'b0;
      as_low_cnt = 0;
    end else begin
      if (u_if.cmd_valid && u_if.cmd_ready) begin
        e.addr  = u_if.cmd_addr;
        e.rw    = u_if.cmd_rw;
        e.mid   = u_if.cmd_rw ? 32'h0 : u_if.cmd_wdata;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.acc   = cyc + 1;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        last_accept = cyc + 1;
      end

      if (!u_if.as_n) begin
        as_low_cnt++;
        if (as_low_cnt == 1) begin
          last_gap    = as_high_cnt;
          as_high_cnt = 0;
          snap_addr   = u_if.addr;
          snap_mid    = u_if.mid;
          if (sb_q.size() > 0) begin
            chk("bus_addr", 64'(u_if.addr), 64'(sb_q[0].addr));
            chk("bus_rw",   64'(u_if.rw),   64'(sb_q[0].rw));
            chk("bus_mid",  64'(u_if.mid),  64'(sb_q[0].mid));
          end else begin
            chk("strobe_unexpected", 64'(1), 64'(0));
          end
        end else begin
          chk("addr_stable", 64'(u_if.addr), 64'(snap_addr));
          chk("mid_stable",  64'(u_if.mid),  64'(snap_mid));
        end
      end else begin
        as_low_cnt = 0;
        as_high_cnt++;
      end

      if (u_if.rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          if (sb_q.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
          else chk("latency", 64'(cyc + 1 - sb_q[0].acc), 64'(sb_q[0].lat));
        end
        if (u_if.rsp_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rsp_rdata", 64'(u_if.rsp_rdata), 64'(e.rdata));
          chk("rsp_err",   64'(u_if.rsp_err),   64'(e.err));
          hs_edge  = cyc + 1;
          rsp_seen = 1'b0;
        end
      end else begin
        rsp_seen = 1'b0;
      end
    end

    // Target: DSK_ low once AS_ has been low for 2+extra falling edges
    u_if.reg_od    = tgt_od;
    u_if.reg_dsk_n = !(as_low_cnt != 0 && as_low_cnt >= 2 + tgt_extra);
  end

  // Drive one command and return once it has been accepted (posedge+2 phase)
  task automatic send_cmd(input logic rw, input logic [7:0] a, input logic [31:0] d,
                          input int extra, input logic [31:0] rd, input logic err,
                          input int lat);
    bit ok = 1'b0;
    tgt_extra      = extra;
    exp_rd         = rd;
    exp_err        = err;
    exp_lat        = lat;
    u_if.cmd_rw    = rw;
    u_if.cmd_addr  = a;
    u_if.cmd_wdata = d;
    u_if.cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u_if.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #2;
    u_if.cmd_valid = 1'b0;
  endtask

  // Wait until all responses have been consumed and the block is idle
  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && u_if.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 64'(0), 64'(1));
    @(posedge clk); #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(u_if.cmd_ready), 64'(1));
    chk({tag, "_rsp_valid"}, 64'(u_if.rsp_valid), 64'(0));
    chk({tag, "_rsp_err"},   64'(u_if.rsp_err),   64'(0));
    chk({tag, "_addr"},      64'(u_if.addr),      64'(0));
    chk({tag, "_dmac_n"},    64'(u_if.dmac_n),    64'(1));
    chk({tag, "_as_n"},      64'(u_if.as_n),      64'(1));
    chk({tag, "_rw"},        64'(u_if.rw),        64'(1));
    chk({tag, "_mid"},       64'(u_if.mid),       64'(0));
    chk({tag, "_busy"},      64'(u_if.busy),      64'(0));
  endtask

  initial begin
    int a0;
    bit ok;
    rst            = 1'b1;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_addr  = '0;
    u_if.cmd_rw    = 1'b0;
    u_if.cmd_wdata = '0;
    u_if.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_rsp_rdata", 64'(u_if.rsp_rdata), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // Write to SSPBDAT, termination on the first WAIT edge
    send_cmd(1'b0, 8'h50, 32'h1234_5678, 0, 32'h0, 1'b0, 5);
    wait_done();

    // Read back, termination three WAIT cycles later
    tgt_od = 32'h1234_5678;
    send_cmd(1'b1, 8'h50, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b0, 8);
    wait_done();

    // Response backpressure
    u_if.rsp_ready = 1'b0;
    tgt_od = 32'hCAFE_F00D;
    send_cmd(1'b1, 8'h10, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 6);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u_if.rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bp_rsp_timeout", 64'(0), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(u_if.rsp_valid), 64'(1));
      chk("bp_rsp_rdata", 64'(u_if.rsp_rdata), 64'(32'hCAFE_F00D));
      chk("bp_cmd_ready", 64'(u_if.cmd_ready), 64'(0));
    end
    @(posedge clk); #2;
    u_if.rsp_ready = 1'b1;
    send_cmd(1'b0, 8'h20, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, 5);
    chk("bp_next_accept", 64'(last_accept), 64'(hs_edge + 1));
    wait_done();

    // Back-to-back commands with RSP_READY high
    send_cmd(1'b0, 8'h30, 32'h1111_2222, 0, 32'h0, 1'b0, 5);
    a0 = last_accept;
    send_cmd(1'b0, 8'h34, 32'h3333_4444, 0, 32'h0, 1'b0, 5);
    chk("b2b_period", 64'(last_accept - a0), 64'(6));
    wait_done();
    chk("b2b_as_gap_ge3", 64'(last_gap >= 3), 64'(1));

`ifdef REGINIT_TIMEOUT_EN
    // Timeout after TB_TMO WAIT cycles with no termination
    send_cmd(1'b1, 8'h44, 32'h0, NEVER, 32'hFFFF_FFFF, 1'b1, 4 + TB_TMO);
    wait_done();
`endif

    // Reset pulsed in WAIT with AS_ low
    send_cmd(1'b0, 8'h60, 32'h5555_AAAA, NEVER, 32'h0, 1'b0, 5);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!u_if.as_n) begin ok = 1'b1; break; end
    end
    if (!ok) chk("as_low_timeout", 64'(0), 64'(1));
`ifdef REGINIT_TIMEOUT_EN
    repeat (2) @(negedge clk);
`else
    repeat (300) @(negedge clk);
    chk("hang_busy", 64'(u_if.busy), 64'(1));
    chk("hang_as_n", 64'(u_if.as_n), 64'(0));
`endif
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_cmd_ready", 64'(u_if.cmd_ready), 64'(1));
    chk("post_rst_busy",      64'(u_if.busy),      64'(0));
    @(posedge clk); #2;
    send_cmd(1'b0, 8'h54, 32'hA5A5_5A5A, 0, 32'h0, 1'b0, 5);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdmac_reg_initiator.md
# sdmac_reg_initiator

Bus-master sequencer that runs CPU-style register cycles (DMAC_, AS_, RW, ADDR, write data) against the SDMAC register file and waits for its REG_DSK_ termination. Write data drives the register file's MID input and read data is captured from its REG_OD output. It accepts one command at a time over a valid/ready request channel and returns read data and status over a valid/ready response channel. It is used by the on-chip self-test and flash-update sequencer to reach the SDMAC registers without an external 68k master.

## Interface
- TIMEOUT_CYCLES, 64: number of WAIT-state cycles without termination before the cycle is aborted (range 2..255).
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_ADDR  in  8  register byte address.
- CMD_RW  in  1  1 = read, 0 = write.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_RDATA  out  32  captured read data; 0 for writes.
- RSP_ERR  out  1  cycle ended by timeout.
- ADDR  out  8  register address to the target.
- DMAC_  out  1  chip select, active-low.
- AS_  out  1  address strobe, active-low.
- RW  out  1  1 = read.
- MID  out  32  write data to the target.
- REG_OD  in  32  read data from the target.
- REG_DSK_  in  1  cycle termination from the target, active-low.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, STROBE, WAIT, RECOVER, RESP.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID, latch ADDR, RW and MID (MID=CMD_WDATA for writes, 0 for reads), then go to SETUP.
- SETUP: DMAC_=0, AS_=1. Go to STROBE.
- STROBE: AS_=0. Go to WAIT.
- WAIT:
  - Sample REG_DSK_ on each rising edge.
  - When REG_DSK_=0: for reads, RSP_RDATA<=REG_OD; for writes, RSP_RDATA<=0. RSP_ERR<=0. Go to RECOVER.
- RECOVER:
  - AS_=1 and DMAC_=1.
  - ADDR, RW and MID hold their values this cycle.
  - RSP_VALID<=1. Go to RESP.
- RESP:
  - ADDR<=0, RW<=1, MID<=0.
  - Hold RSP_* until RSP_READY=1, then RSP_VALID<=0 and go to IDLE.
- ADDR, RW and MID are stable from SETUP through RECOVER inclusive. They never change while AS_=0.
- REG_DSK_ is ignored outside WAIT. A termination that is already low on entry to WAIT is accepted on the first WAIT edge.
- Every output is registered. No combinational path from an input to an output.

## Timing
- Reset values: CMD_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, ADDR=0, DMAC_=1, AS_=1, RW=1, MID=0, BUSY=0. State = IDLE.
- Cycle sequence (edge n = command accepted):
  - n+1: DMAC_ low.
  - n+2: AS_ low.
  - First REG_DSK_ sample at edge n+3.
  - If terminated there: AS_/DMAC_ high at n+4, RSP_VALID high at n+5.
- Minimum command-to-response latency is 5 cycles. Each extra WAIT cycle adds one.
- Back-to-back commands: with RSP_READY held high, the next command is accepted one cycle after the response handshake, at the earliest. Minimum period is 6 cycles.
- Reset mid-cycle (RST asserted in any state): all outputs return to their reset values immediately and asynchronously, including AS_/DMAC_ negation. An in-flight response is discarded.

## Configuration
- REGINIT_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no termination: RSP_RDATA<=32'hFFFFFFFF, RSP_ERR<=1, go to RECOVER.
  - If termination and timeout occur on the same edge, termination wins and RSP_ERR=0.
- REGINIT_TIMEOUT_EN undefined: WAIT waits indefinitely, RSP_ERR is tied to 0, and no counter is instantiated.

## Test plan
- Write to SSPBDAT: CMD addr 8'h50, RW=0, data 32'h12345678, target terminates on the first WAIT edge -> MID=32'h12345678 while AS_=0; RSP_VALID 5 cycles after accept; RSP_RDATA=0, RSP_ERR=0.
- Read back the same address, with the target driving REG_OD=32'h12345678 and REG_DSK_ low 4 cycles after AS_ falls -> RSP_RDATA=32'h12345678, latency 8 cycles; ADDR stable throughout AS_ low.
- Timeout, with REGINIT_TIMEOUT_EN and TIMEOUT_CYCLES=8, REG_DSK_ held high -> AS_ negates after 8 WAIT cycles; RSP_ERR=1, RSP_RDATA=32'hFFFFFFFF. Without the macro, the block is still in WAIT after 300 cycles.
- Response backpressure: RSP_READY held low for 10 cycles -> RSP_* stable and CMD_READY=0 throughout; next command accepted one cycle after the handshake.
- RST pulsed while in WAIT with AS_=0 -> AS_, DMAC_ and RW are 1 and MID, ADDR and RSP_VALID are 0 before the next clock edge; block idle after RST falls.
- Two queued commands with RSP_READY tied high -> accepts 6 cycles apart, and AS_ shows at least 3 cycles high between the two strobes.
